// File: rtl/mcp300x_responder_if.sv
// SPI pins shared by the MCP300x-style ADC emulator and whatever masters it.
// MISO_oe tells the pad ring when MISO should leave high-Z.
interface mcp300x_responder_if;
    logic SCLK;
    logic CS;
    logic MOSI;
    logic MISO;
    logic MISO_oe;

    modport master (output SCLK, output CS, output MOSI, input MISO, input MISO_oe);
    modport slave  (input SCLK, input CS, input MOSI, output MISO, output MISO_oe);
endinterface

// File: rtl/mcp300x_responder.sv
// Emulates an MCP3004/3008 ADC on SPI mode 0: decodes the start/SGL/D2..D0 command
// and shifts back a null bit plus a 10-bit result taken from ch_values.
module mcp300x_responder #(
    parameter int NUM_CHANNELS = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                         clk_oversample,
    input  logic                         reset,
    mcp300x_responder_if.slave           spi,
    input  logic [10*NUM_CHANNELS-1:0]   ch_values,
    output logic                         cmd_valid,
    output logic                         cmd_single,
    output logic [2:0]                   cmd_channel,
    output logic                         busy,
    output logic                         frame_error
);
    localparam int IDX_W   = (NUM_CHANNELS == 4) ? 2 : 3;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_START, CMD, SAMPLE, NULLBIT, DATA, TRAIL} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t         state_q, state_d;
    logic [2:0]     cmd_shift_q, cmd_shift_d;
    logic [1:0]     cmd_cnt_q, cmd_cnt_d;
    logic [3:0]     bit_idx_q, bit_idx_d;
    logic [9:0]     result_q, result_d;
    logic           miso_q, miso_d, oe_q, oe_d;
    logic           cmd_valid_q, cmd_valid_d, cmd_single_q, cmd_single_d;
    logic [2:0]     cmd_channel_q, cmd_channel_d;
    logic           busy_q, busy_d, frame_error_q, frame_error_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic           armed_q, armed_d;

    logic [9:0]       ch_arr [NUM_CHANNELS];
    logic [3:0]       cmd_word;
    logic [IDX_W-1:0] pos_idx, neg_idx;
    logic [9:0]       in_pos, in_neg, conv;
    logic [10:0]      diff;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sclk_sync_d[gi] = spi.SCLK;
                assign cs_sync_d[gi]   = spi.CS;
                assign mosi_sync_d[gi] = spi.MOSI;
            end else begin : g_rest
                assign sclk_sync_d[gi] = sclk_sync_q[gi-1];
                assign cs_sync_d[gi]   = cs_sync_q[gi-1];
                assign mosi_sync_d[gi] = mosi_sync_q[gi-1];
            end
        end
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            assign ch_arr[gi] = ch_values[10*gi +: 10];
        end
    endgenerate

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // The differential "minus" input is always the other channel of the same pair.
    assign cmd_word = {cmd_shift_q, mosi_s};
    assign pos_idx  = cmd_word[IDX_W-1:0];
    assign neg_idx  = {pos_idx[IDX_W-1:1], ~pos_idx[0]};
    assign in_pos   = ch_arr[pos_idx];
    assign in_neg   = ch_arr[neg_idx];
    assign diff     = {1'b0, in_pos} - {1'b0, in_neg};
    assign conv     = cmd_word[3] ? in_pos : (diff[10] ? 10'd0 : diff[9:0]);

    always_comb begin
        state_d       = state_q;
        cmd_shift_d   = cmd_shift_q;
        cmd_cnt_d     = cmd_cnt_q;
        bit_idx_d     = bit_idx_q;
        result_d      = result_q;
        miso_d        = miso_q;
        oe_d          = oe_q;
        cmd_valid_d   = 1'b0;
        cmd_single_d  = cmd_single_q;
        cmd_channel_d = cmd_channel_q;
        busy_d        = ~cs_s;
        frame_error_d = 1'b0;
        flush_d       = (flush_q == FLUSH_LAST) ? flush_q : flush_q + 1'b1;
        // A CS low edge manufactured by the post-reset synchroniser flush must not open a frame.
        armed_d       = armed_q | ((flush_q == FLUSH_LAST) & cs_s);

        if (cs_rise) begin
            state_d       = IDLE;
            miso_d        = 1'b0;
            oe_d          = 1'b0;
            frame_error_d = (state_q inside {CMD, SAMPLE, NULLBIT, DATA});
        end else if (cs_fall && armed_q) begin
            state_d = WAIT_START;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_START: begin
                    if (sclk_rise && mosi_s) begin
                        state_d     = CMD;
                        cmd_cnt_d   = 2'd0;
                        cmd_shift_d = 3'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_shift_d = {cmd_shift_q[1:0], mosi_s};
                        cmd_cnt_d   = cmd_cnt_q + 2'd1;
                        if (cmd_cnt_q == 2'd3) begin
                            state_d       = SAMPLE;
                            result_d      = conv;
                            cmd_valid_d   = 1'b1;
                            cmd_single_d  = cmd_word[3];
                            cmd_channel_d = cmd_word[2:0];
                        end
                    end
                end
                SAMPLE: begin
                    if (sclk_rise) state_d = NULLBIT;
                end
                NULLBIT: begin
                    if (sclk_fall) begin
                        oe_d   = 1'b1;
                        miso_d = 1'b0;
                    end
                    if (sclk_rise) begin
                        state_d   = DATA;
                        bit_idx_d = 4'd9;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        miso_d = result_q[bit_idx_q];
                        if (bit_idx_q == 4'd0) state_d = TRAIL;
                        else bit_idx_d = bit_idx_q - 4'd1;
                    end
                end
                TRAIL: begin
                    if (sclk_fall) miso_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_oversample) begin
        if (reset) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            state_q       <= IDLE;
            cmd_shift_q   <= 3'd0;
            cmd_cnt_q     <= 2'd0;
            bit_idx_q     <= 4'd0;
            result_q      <= 10'd0;
            miso_q        <= 1'b0;
            oe_q          <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_single_q  <= 1'b0;
            cmd_channel_q <= 3'd0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            flush_q       <= '0;
            armed_q       <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            state_q       <= state_d;
            cmd_shift_q   <= cmd_shift_d;
            cmd_cnt_q     <= cmd_cnt_d;
            bit_idx_q     <= bit_idx_d;
            result_q      <= result_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_single_q  <= cmd_single_d;
            cmd_channel_q <= cmd_channel_d;
            busy_q        <= busy_d;
            frame_error_q <= frame_error_d;
            flush_q       <= flush_d;
            armed_q       <= armed_d;
        end
    end

    assign spi.MISO    = miso_q;
    assign spi.MISO_oe = oe_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_single  = cmd_single_q;
    assign cmd_channel = cmd_channel_q;
    assign busy        = busy_q;
    assign frame_error = frame_error_q;
endmodule

// File: doc/mcp300x_responder.md
MCP300X_RESPONDER -- requirements
Module: mcp300x_responder

Interface
REQ-001 NUM_CHANNELS, 8, number of emulated ADC inputs; legal values 4 or 8; with 4, command bit D2 is ignored.
REQ-002 SYNC_STAGES, 2, flip-flop stages on each of SCLK, CS and MOSI; minimum 2.
REQ-003 clk_oversample  input  1  sole clock; frequency SHALL be at least 8x the SCLK frequency.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SCLK  input  1  serial clock from the master, asynchronous to clk_oversample; idles low.
REQ-006 CS  input  1  active-low chip select, asynchronous.
REQ-007 MOSI  input  1  command bits from the master, asynchronous.
REQ-008 ch_values  input  10*NUM_CHANNELS  unsigned channel samples; channel n occupies bits [10n+9:10n].
REQ-009 MISO  output  1  serial result to the master.
REQ-010 MISO_oe  output  1  1 = MISO actively driven; 0 = high-Z at the pad.
REQ-011 cmd_valid  output  1  one-cycle pulse when a full command has been decoded.
REQ-012 cmd_single  output  1  SGL/DIFF bit of the last decoded command.
REQ-013 cmd_channel  output  3  D2..D0 of the last decoded command.
REQ-014 busy  output  1  high while CS is synchronised low.
REQ-015 frame_error  output  1  one-cycle pulse when CS rises before the B0 bit has been driven.

Function
REQ-016 SCLK, CS and MOSI SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronised SCLK and CS only.
REQ-017 States: IDLE, WAIT_START, CMD, SAMPLE, NULLBIT, DATA, TRAIL.
REQ-018 IDLE: CS low edge -> WAIT_START.
REQ-019 WAIT_START: an SCLK rising edge with MOSI=0 SHALL be ignored (leading zeros); a rising edge with MOSI=1 is the start bit -> CMD.
REQ-020 CMD: the next 4 rising edges SHALL sample SGL, D2, D1, D0, shifted MSB first.
REQ-021 On the D0 rising edge: compute and latch the 10-bit result; go to SAMPLE; pulse cmd_valid on the following cycle; update cmd_single and cmd_channel.
REQ-022 Single-ended result: ch_values[channel], with channel = {D2,D1,D0}, or {D1,D0} when NUM_CHANNELS=4.
REQ-023 Differential result: pair p = channel>>1; IN+ = ch(2p), IN- = ch(2p+1) when D0=0, operands swapped when D0=1; result = IN+ minus IN- when IN+ >= IN-, else 0 (11-bit compare, no wrap).
REQ-024 SAMPLE: the next rising edge (6th after start) -> NULLBIT; on the following falling edge assert MISO_oe with MISO=0.
REQ-025 NULLBIT: the next rising edge -> DATA; falling edges after rising edges 7..16 SHALL drive B9..B0, MSB first.
REQ-026 After the falling edge that drives B0 -> TRAIL; MISO=0, MISO_oe stays 1 until CS rises.
REQ-027 MISO SHALL change no later than SYNC_STAGES+2 clk_oversample cycles after the SCLK falling edge at the pin, and SHALL never change on a rising edge.
REQ-028 CS rising edge in any state SHALL return to IDLE in the same cycle; MISO=0, MISO_oe=0, busy=0.
REQ-029 frame_error pulses if that CS rise occurs in CMD, SAMPLE, NULLBIT or DATA; no pulse from WAIT_START or TRAIL.
REQ-030 ch_values SHALL be sampled only at the D0 edge; later changes do not affect the frame in flight.
REQ-031 SCLK edges while CS is high SHALL be ignored.
REQ-032 A CS falling edge while not in IDLE (glitch) SHALL restart at WAIT_START.

Reset
REQ-033 Reset: state=IDLE; MISO=0; MISO_oe=0; cmd_valid=0; cmd_single=0; cmd_channel=0; busy=0; frame_error=0; synchroniser flops=0, except CS flops=1.
REQ-034 Reset asserted mid-frame SHALL take effect on the next clock edge; no frame_error pulse; a new frame requires a fresh CS falling edge.

Verification
REQ-035 Single-ended read: NUM_CHANNELS=8, ch3=0x2A5, master sends 1,1,0,1,1 plus one wait clock -> cmd_valid once, cmd_channel=3, cmd_single=1; master's 11 reads = 0 then 1010100101.
REQ-036 Differential read: ch0=300, ch1=100, cmd SGL=0 D=000 -> result 200 (0011001000); the same frame with D=001 -> 0000000000.
REQ-037 Three leading MOSI zeros before the start bit, ch7=0x3FF -> response identical to an unpadded frame; all 10 bits are 1.
REQ-038 CS raised after 8 SCLK rising edges -> frame_error one pulse; MISO_oe=0; the next full frame is correct.
REQ-039 NUM_CHANNELS=4, command D2..D0=110, ch2=0x155 -> result 0x155.
REQ-040 Reset asserted during DATA, then a new frame -> MISO_oe=0 after reset, no frame_error, second frame correct.
